id_stage_pipe: RTL and testbench

- Parametrised successor to the combinational decode stage: full RV32I/RV32E decode, register file, immediate generation, and a registered ID/EX pipeline boundary.
- Adds a valid/ready handshake on both sides, flush, load-use hazard bubbles, and an illegal-instruction flag.
- Sits between the fetch stage and the execute stage of the 5-stage core.

---
 rtl/id_stage_pipe_if.sv | 49 ++++
 rtl/id_stage_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: fetch, writeback and ID/EX signal bundle for the decode stage
interface id_stage_pipe_if #(
    parameter int XLEN = 32
);
    logic            if_valid_i;
    logic            if_ready_o;
    logic [31:0]     ins_i;
    logic [XLEN-1:0] pc_i;
    logic            flush_i;
    logic            ex_ready_i;
    logic            ex_valid_o;
    logic            wb_we_i;
    logic [4:0]      wb_waddr_i;
    logic [XLEN-1:0] wb_wdata_i;
    logic [XLEN-1:0] ex_pc_o;
    logic [XLEN-1:0] ex_d1_o;
    logic [XLEN-1:0] ex_d2_o;
    logic [XLEN-1:0] ex_imm_o;
    logic [4:0]      ex_rs1_o;
    logic [4:0]      ex_rs2_o;
    logic [4:0]      ex_rd_o;
    logic [2:0]      ex_f3_o;
    logic [6:0]      ex_f7_o;
    logic            ex_imm_sel_o;
    logic            ex_pc_sel_o;
    logic            ex_jmp_o;
    logic            ex_br_o;
    logic            ex_lui_o;
    logic            ex_mem_re_o;
    logic            ex_mem_wr_o;
    logic [2:0]      ex_mem_f3_o;
    logic            ex_wb_reg_wr_o;
    logic            ex_wb_mem_sel_o;
    logic            ex_illegal_o;

    modport master (
        output if_valid_i, ins_i, pc_i, flush_i, ex_ready_i, wb_we_i, wb_waddr_i, wb_wdata_i,
        input  if_ready_o, ex_valid_o, ex_pc_o, ex_d1_o, ex_d2_o, ex_imm_o, ex_rs1_o, ex_rs2_o,
               ex_rd_o, ex_f3_o, ex_f7_o, ex_imm_sel_o, ex_pc_sel_o, ex_jmp_o, ex_br_o, ex_lui_o,
               ex_mem_re_o, ex_mem_wr_o, ex_mem_f3_o, ex_wb_reg_wr_o, ex_wb_mem_sel_o, ex_illegal_o
    );

    modport slave (
        input  if_valid_i, ins_i, pc_i, flush_i, ex_ready_i, wb_we_i, wb_waddr_i, wb_wdata_i,
        output if_ready_o, ex_valid_o, ex_pc_o, ex_d1_o, ex_d2_o, ex_imm_o, ex_rs1_o, ex_rs2_o,
               ex_rd_o, ex_f3_o, ex_f7_o, ex_imm_sel_o, ex_pc_sel_o, ex_jmp_o, ex_br_o, ex_lui_o,
               ex_mem_re_o, ex_mem_wr_o, ex_mem_f3_o, ex_wb_reg_wr_o, ex_wb_mem_sel_o, ex_illegal_o
    );
endinterface

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32I/RV32E decode, register file and ID/EX register; ID_RF_BYPASS_EN enables write-through reads
module id_stage_pipe #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           rst,
    id_stage_pipe_if.slave bus
);
    localparam int         AW = $clog2(NREGS);
    localparam logic [5:0] NR = 6'(NREGS);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [2:0] f3;
        logic [6:0] f7;
        logic       imm_sel;
        logic       pc_sel;
        logic       jmp;
        logic       br;
        logic       lui;
        logic       mem_re;
        logic       mem_wr;
        logic [2:0] mem_f3;
        logic       wb_reg_wr;
        logic       wb_mem_sel;
    } ctrl_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] d1;
        logic [XLEN-1:0] d2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        ctrl_t           ctrl;
        logic            illegal;
    } idex_t;

    logic [XLEN-1:0] rf [NREGS];
    logic [XLEN-1:0] rd1, rd2;
    logic [6:0]      op, f7;
    logic [2:0]      f3;
    logic [4:0]      rs1, rs2, rd;
    logic            legal, rs1_use, rs2_use, rd_use, bad_idx;
    logic            load, hazard, take, wr_ok;
    idex_t           d, q, bubble;

    assign op  = bus.ins_i[6:0];
    assign rd  = bus.ins_i[11:7];
    assign f3  = bus.ins_i[14:12];
    assign rs1 = bus.ins_i[19:15];
    assign rs2 = bus.ins_i[24:20];
    assign f7  = bus.ins_i[31:25];

    assign wr_ok = bus.wb_we_i && bus.wb_waddr_i != '0 && {1'b0, bus.wb_waddr_i} < NR;

    // register file write port; x0 and indices beyond NREGS are never written
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        else if (wr_ok)
            rf[bus.wb_waddr_i[AW-1:0]] <= bus.wb_wdata_i;

    // combinational register reads, optionally forwarding the same-cycle writeback
    always_comb begin
        rd1 = (rs1 == '0 || {1'b0, rs1} >= NR) ? '0 : rf[rs1[AW-1:0]];
        rd2 = (rs2 == '0 || {1'b0, rs2} >= NR) ? '0 : rf[rs2[AW-1:0]];
`ifdef ID_RF_BYPASS_EN
        if (bus.wb_we_i && rs1 != '0 && bus.wb_waddr_i == rs1) rd1 = bus.wb_wdata_i;
        if (bus.wb_we_i && rs2 != '0 && bus.wb_waddr_i == rs2) rd2 = bus.wb_wdata_i;
`endif
    end

    // decode: legality, operand usage, immediate and control word
    always_comb begin
        d       = '0;
        legal   = 1'b0;
        rs1_use = 1'b1;
        rs2_use = 1'b0;
        rd_use  = 1'b0;
        d.valid = 1'b1;
        d.pc    = bus.pc_i;
        d.d1    = rd1;
        d.d2    = rd2;
        case (op)
            OP_LUI: begin
                legal = 1'b1; rs1_use = 1'b0; rd_use = 1'b1;
                d.imm = XLEN'($signed({bus.ins_i[31:12], 12'b0}));
                d.ctrl.imm_sel = 1'b1; d.ctrl.lui = 1'b1;
            end
            OP_AUIPC: begin
                legal = 1'b1; rs1_use = 1'b0; rd_use = 1'b1;
                d.imm = XLEN'($signed({bus.ins_i[31:12], 12'b0}));
                d.ctrl.imm_sel = 1'b1; d.ctrl.pc_sel = 1'b1;
            end
            OP_JAL: begin
                legal = 1'b1; rs1_use = 1'b0; rd_use = 1'b1;
                d.imm = XLEN'($signed({bus.ins_i[31], bus.ins_i[19:12], bus.ins_i[20], bus.ins_i[30:21], 1'b0}));
                d.ctrl.imm_sel = 1'b1; d.ctrl.pc_sel = 1'b1; d.ctrl.jmp = 1'b1;
            end
            OP_JALR: begin
                legal = f3 == 3'b000; rd_use = 1'b1;
                d.imm = XLEN'($signed(bus.ins_i[31:20]));
                d.ctrl.imm_sel = 1'b1; d.ctrl.jmp = 1'b1; d.ctrl.f3 = f3;
            end
            OP_BRANCH: begin
                legal = f3[2:1] != 2'b01; rs2_use = 1'b1;
                d.imm = XLEN'($signed({bus.ins_i[31], bus.ins_i[7], bus.ins_i[30:25], bus.ins_i[11:8], 1'b0}));
                d.ctrl.br = 1'b1; d.ctrl.f3 = f3;
            end
            OP_LOAD: begin
                legal = f3 != 3'b011 && f3[2:1] != 2'b11; rd_use = 1'b1;
                d.imm = XLEN'($signed(bus.ins_i[31:20]));
                d.ctrl.imm_sel = 1'b1; d.ctrl.mem_re = 1'b1; d.ctrl.mem_f3 = f3;
                d.ctrl.wb_mem_sel = 1'b1; d.ctrl.f3 = f3;
            end
            OP_STORE: begin
                legal = f3 < 3'b011; rs2_use = 1'b1;
                d.imm = XLEN'($signed({bus.ins_i[31:25], bus.ins_i[11:7]}));
                d.ctrl.imm_sel = 1'b1; d.ctrl.mem_wr = 1'b1; d.ctrl.mem_f3 = f3; d.ctrl.f3 = f3;
            end
            OP_IMM: begin
                legal = f3 == 3'b001 ? f7 == 7'h00 : f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                rd_use = 1'b1;
                d.imm = XLEN'($signed(bus.ins_i[31:20]));
                d.ctrl.imm_sel = 1'b1; d.ctrl.f3 = f3;
                d.ctrl.f7 = f3[1:0] == 2'b01 ? f7 : 7'h00;
            end
            OP_OP: begin
                legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
                rs2_use = 1'b1; rd_use = 1'b1;
                d.ctrl.f3 = f3; d.ctrl.f7 = f7;
            end
            OP_SYSTEM: begin
                legal = 1'b1;
                d.imm = XLEN'($signed(bus.ins_i[31:20]));
                d.ctrl.f3 = f3;
            end
            default: legal = 1'b0;
        endcase
        d.ctrl.wb_reg_wr = rd_use;
        bad_idx = (rs1_use && {1'b0, rs1} >= NR) || (rs2_use && {1'b0, rs2} >= NR) ||
                  (rd_use && {1'b0, rd} >= NR);
        d.rs1 = rs1_use ? rs1 : '0;
        d.rs2 = rs2_use ? rs2 : '0;
        d.rd  = rd_use ? rd : '0;
        if (!legal || bad_idx) begin
            d.ctrl    = '0;
            d.rd      = '0;
            d.illegal = 1'b1;
        end
    end

    assign load   = !q.valid || bus.ex_ready_i;
    assign hazard = q.valid && q.ctrl.mem_re && q.rd != '0 && bus.if_valid_i &&
                    ((q.rd == rs1 && rs1_use) || (q.rd == rs2 && rs2_use));
    assign take   = bus.if_valid_i && !hazard && !bus.flush_i;
    assign bus.if_ready_o = bus.flush_i || (load && !hazard);

    // a bubble keeps the data fields but kills validity and every control
    always_comb begin
        bubble         = q;
        bubble.valid   = 1'b0;
        bubble.ctrl    = '0;
        bubble.illegal = 1'b0;
    end

    // ID/EX register: flush wins, then bubble or capture when execute can take it
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            q    <= '0;
            q.pc <= RESET_PC;
        end else if (bus.flush_i || (load && !take))
            q <= bubble;
        else if (load)
            q <= d;

    assign bus.ex_valid_o      = q.valid;
    assign bus.ex_pc_o         = q.pc;
    assign bus.ex_d1_o         = q.d1;
    assign bus.ex_d2_o         = q.d2;
    assign bus.ex_imm_o        = q.imm;
    assign bus.ex_rs1_o        = q.rs1;
    assign bus.ex_rs2_o        = q.rs2;
    assign bus.ex_rd_o         = q.rd;
    assign bus.ex_f3_o         = q.ctrl.f3;
    assign bus.ex_f7_o         = q.ctrl.f7;
    assign bus.ex_imm_sel_o    = q.ctrl.imm_sel;
    assign bus.ex_pc_sel_o     = q.ctrl.pc_sel;
    assign bus.ex_jmp_o        = q.ctrl.jmp;
    assign bus.ex_br_o         = q.ctrl.br;
    assign bus.ex_lui_o        = q.ctrl.lui;
    assign bus.ex_mem_re_o     = q.ctrl.mem_re;
    assign bus.ex_mem_wr_o     = q.ctrl.mem_wr;
    assign bus.ex_mem_f3_o     = q.ctrl.mem_f3;
    assign bus.ex_wb_reg_wr_o  = q.ctrl.wb_reg_wr;
    assign bus.ex_wb_mem_sel_o = q.ctrl.wb_mem_sel;
    assign bus.ex_illegal_o    = q.illegal;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed checks of decode, hazards, handshake, flush and register file
module tb_id_stage_pipe;
    localparam logic [6:0] OPR = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011, JALR = 7'b1100111;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   chk = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    id_stage_pipe_if #(.XLEN(32)) bus ();
    id_stage_pipe_if #(.XLEN(32)) bus16 ();

    id_stage_pipe #(.XLEN(32), .NREGS(32), .RESET_PC(32'h100)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    id_stage_pipe #(.XLEN(32), .NREGS(16), .RESET_PC(32'h0)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], ST};
    endfunction

    function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] i, input logic [31:0] p);
        bus.ins_i = i;
        bus.pc_i = p;
        bus.if_valid_i = 1'b1;
        tick();
        bus.if_valid_i = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] v);
        bus.wb_we_i = 1'b1;
        bus.wb_waddr_i = a;
        bus.wb_wdata_i = v;
        tick();
        bus.wb_we_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        chk++; if (bus.ex_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got=%h exp=0", bus.ex_valid_o); end
        chk++; if (bus.ex_pc_o !== 32'h100) begin fails++; $display("FAIL reset_pc got=%h exp=00000100", bus.ex_pc_o); end
        chk++; if (bus.ex_imm_o !== 32'h0 || bus.ex_wb_reg_wr_o !== 1'b0 || bus.ex_illegal_o !== 1'b0)
            begin fails++; $display("FAIL reset_fields imm=%h wr=%h ill=%h exp=0", bus.ex_imm_o, bus.ex_wb_reg_wr_o, bus.ex_illegal_o); end
        rst = 1'b1;
        #1;
        chk++; if (bus.if_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got=%h exp=1", bus.if_ready_o); end
    endtask

    task automatic test_addi();
        wr(5'd5, 32'h1234);
        wr(5'd1, 32'h10);
        wr(5'd2, 32'h22);
        bus.ins_i = 32'hFFF28313;
        bus.pc_i = 32'h40;
        bus.if_valid_i = 1'b1;
        #1;
        chk++; if (bus.if_ready_o !== 1'b1) begin fails++; $display("FAIL addi_ready got=%h exp=1", bus.if_ready_o); end
        tick();
        bus.if_valid_i = 1'b0;
        chk++; if (bus.ex_valid_o !== 1'b1) begin fails++; $display("FAIL addi_valid got=%h exp=1", bus.ex_valid_o); end
        chk++; if (bus.ex_d1_o !== 32'h1234) begin fails++; $display("FAIL addi_d1 got=%h exp=00001234", bus.ex_d1_o); end
        chk++; if (bus.ex_imm_o !== 32'hFFFFFFFF) begin fails++; $display("FAIL addi_imm got=%h exp=ffffffff", bus.ex_imm_o); end
        chk++; if (bus.ex_imm_sel_o !== 1'b1 || bus.ex_wb_reg_wr_o !== 1'b1)
            begin fails++; $display("FAIL addi_ctrl imm_sel=%h wr=%h exp=1,1", bus.ex_imm_sel_o, bus.ex_wb_reg_wr_o); end
        chk++; if (bus.ex_rd_o !== 5'd6 || bus.ex_rs1_o !== 5'd5 || bus.ex_pc_o !== 32'h40)
            begin fails++; $display("FAIL addi_regs rd=%0d rs1=%0d pc=%h exp=6,5,40", bus.ex_rd_o, bus.ex_rs1_o, bus.ex_pc_o); end
        tick();
        chk++; if (bus.ex_valid_o !== 1'b0 || bus.ex_wb_reg_wr_o !== 1'b0)
            begin fails++; $display("FAIL idle_bubble valid=%h wr=%h exp=0,0", bus.ex_valid_o, bus.ex_wb_reg_wr_o); end
    endtask

    task automatic test_imm();
        issue({20'h12345, 5'd3, 7'b0110111}, 32'h50);
        chk++; if (bus.ex_imm_o !== 32'h12345000 || bus.ex_lui_o !== 1'b1 || bus.ex_wb_reg_wr_o !== 1'b1)
            begin fails++; $display("FAIL lui imm=%h lui=%h wr=%h exp=12345000,1,1", bus.ex_imm_o, bus.ex_lui_o, bus.ex_wb_reg_wr_o); end
        issue(j_t(21'h1FFFF8, 5'd1), 32'h80);
        chk++; if (bus.ex_imm_o !== 32'hFFFFFFF8 || bus.ex_jmp_o !== 1'b1 || bus.ex_pc_sel_o !== 1'b1 || bus.ex_wb_reg_wr_o !== 1'b1)
            begin fails++; $display("FAIL jal imm=%h jmp=%h pc_sel=%h wr=%h exp=fffffff8,1,1,1", bus.ex_imm_o, bus.ex_jmp_o, bus.ex_pc_sel_o, bus.ex_wb_reg_wr_o); end
        issue(b_t(13'h1FFC, 5'd2, 5'd1, 3'b000), 32'h84);
        chk++; if (bus.ex_imm_o !== 32'hFFFFFFFC || bus.ex_br_o !== 1'b1 || bus.ex_wb_reg_wr_o !== 1'b0)
            begin fails++; $display("FAIL beq_ctrl imm=%h br=%h wr=%h exp=fffffffc,1,0", bus.ex_imm_o, bus.ex_br_o, bus.ex_wb_reg_wr_o); end
        chk++; if (bus.ex_d1_o !== 32'h10 || bus.ex_d2_o !== 32'h22 || bus.ex_rs2_o !== 5'd2)
            begin fails++; $display("FAIL beq_data d1=%h d2=%h rs2=%0d exp=10,22,2", bus.ex_d1_o, bus.ex_d2_o, bus.ex_rs2_o); end
        issue(s_t(12'd12, 5'd2, 5'd1, 3'b010), 32'h88);
        chk++; if (bus.ex_imm_o !== 32'hC || bus.ex_mem_wr_o !== 1'b1 || bus.ex_mem_f3_o !== 3'b010 || bus.ex_d2_o !== 32'h22 || bus.ex_wb_reg_wr_o !== 1'b0)
            begin fails++; $display("FAIL sw imm=%h wr=%h f3=%h d2=%h rwr=%h exp=c,1,2,22,0", bus.ex_imm_o, bus.ex_mem_wr_o, bus.ex_mem_f3_o, bus.ex_d2_o, bus.ex_wb_reg_wr_o); end
    endtask

    task automatic test_load_use();
        issue(i_t(12'd0, 5'd1, 3'b010, 5'd7, LD), 32'h100);
        chk++; if (bus.ex_mem_re_o !== 1'b1 || bus.ex_wb_mem_sel_o !== 1'b1 || bus.ex_mem_f3_o !== 3'b010 || bus.ex_rd_o !== 5'd7)
            begin fails++; $display("FAIL lw_ctrl re=%h sel=%h f3=%h rd=%0d exp=1,1,2,7", bus.ex_mem_re_o, bus.ex_wb_mem_sel_o, bus.ex_mem_f3_o, bus.ex_rd_o); end
        bus.ins_i = r_t(7'h00, 5'd2, 5'd7, 3'b000, 5'd8, OPR);
        bus.if_valid_i = 1'b1;
        #1;
        chk++; if (bus.if_ready_o !== 1'b0) begin fails++; $display("FAIL lu_stall_ready got=%h exp=0", bus.if_ready_o); end
        tick();
        chk++; if (bus.ex_valid_o !== 1'b0) begin fails++; $display("FAIL lu_bubble got=%h exp=0", bus.ex_valid_o); end
        chk++; if (bus.if_ready_o !== 1'b1) begin fails++; $display("FAIL lu_release_ready got=%h exp=1", bus.if_ready_o); end
        tick();
        bus.if_valid_i = 1'b0;
        chk++; if (bus.ex_valid_o !== 1'b1 || bus.ex_rd_o !== 5'd8 || bus.ex_d2_o !== 32'h22)
            begin fails++; $display("FAIL lu_issue valid=%h rd=%0d d2=%h exp=1,8,22", bus.ex_valid_o, bus.ex_rd_o, bus.ex_d2_o); end
        issue(i_t(12'd0, 5'd1, 3'b010, 5'd7, LD), 32'h110);
        bus.ins_i = r_t(7'h00, 5'd7, 5'd2, 3'b000, 5'd8, OPR);
        bus.if_valid_i = 1'b1;
        #1;
        chk++; if (bus.if_ready_o !== 1'b0) begin fails++; $display("FAIL lu_rs2_ready got=%h exp=0", bus.if_ready_o); end
        tick();
        tick();
        bus.if_valid_i = 1'b0;
        issue(i_t(12'd0, 5'd1, 3'b010, 5'd0, LD), 32'h120);
        bus.ins_i = r_t(7'h00, 5'd2, 5'd0, 3'b000, 5'd8, OPR);
        bus.if_valid_i = 1'b1;
        #1;
        chk++; if (bus.if_ready_o !== 1'b1) begin fails++; $display("FAIL lu_x0_ready got=%h exp=1", bus.if_ready_o); end
        tick();
        chk++; if (bus.ex_valid_o !== 1'b1) begin fails++; $display("FAIL lu_x0_issue got=%h exp=1", bus.ex_valid_o); end
        bus.if_valid_i = 1'b0;
        issue(i_t(12'd0, 5'd1, 3'b010, 5'd7, LD), 32'h130);
        bus.ins_i = r_t(7'h00, 5'd2, 5'd3, 3'b000, 5'd8, OPR);
        bus.if_valid_i = 1'b1;
        #1;
        chk++; if (bus.if_ready_o !== 1'b1) begin fails++; $display("FAIL lu_unrel_ready got=%h exp=1", bus.if_ready_o); end
        tick();
        bus.if_valid_i = 1'b0;
        issue(i_t(12'd0, 5'd1, 3'b010, 5'd7, LD), 32'h140);
        bus.ins_i = i_t(12'd7, 5'd1, 3'b000, 5'd8, OPI);
        bus.if_valid_i = 1'b1;
        #1;
        chk++; if (bus.if_ready_o !== 1'b1) begin fails++; $display("FAIL lu_rs2_unused_ready got=%h exp=1", bus.if_ready_o); end
        tick();
        bus.if_valid_i = 1'b0;
        chk++; if (bus.ex_valid_o !== 1'b1 || bus.ex_imm_o !== 32'd7)
            begin fails++; $display("FAIL lu_rs2_unused_issue valid=%h imm=%h exp=1,7", bus.ex_valid_o, bus.ex_imm_o); end
    endtask

    task automatic test_stall();
        issue(32'hFFF28313, 32'h200);
        bus.ex_ready_i = 1'b0;
        bus.ins_i = i_t(12'd5, 5'd5, 3'b000, 5'd9, OPI);
        bus.pc_i = 32'h204;
        bus.if_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk++; if (bus.if_ready_o !== 1'b0) begin fails++; $display("FAIL stall_ready%0d got=%h exp=0", k, bus.if_ready_o); end
            tick();
            chk++; if (bus.ex_valid_o !== 1'b1 || bus.ex_rd_o !== 5'd6 || bus.ex_imm_o !== 32'hFFFFFFFF || bus.ex_pc_o !== 32'h200)
                begin fails++; $display("FAIL stall_hold%0d valid=%h rd=%0d imm=%h pc=%h exp=1,6,ffffffff,200", k, bus.ex_valid_o, bus.ex_rd_o, bus.ex_imm_o, bus.ex_pc_o); end
        end
        bus.ex_ready_i = 1'b1;
        #1;
        chk++; if (bus.if_ready_o !== 1'b1) begin fails++; $display("FAIL stall_release_ready got=%h exp=1", bus.if_ready_o); end
        tick();
        bus.if_valid_i = 1'b0;
        chk++; if (bus.ex_rd_o !== 5'd9 || bus.ex_imm_o !== 32'd5 || bus.ex_d1_o !== 32'h1234 || bus.ex_pc_o !== 32'h204)
            begin fails++; $display("FAIL stall_next rd=%0d imm=%h d1=%h pc=%h exp=9,5,1234,204", bus.ex_rd_o, bus.ex_imm_o, bus.ex_d1_o, bus.ex_pc_o); end
    endtask

    task automatic test_flush();
        issue(32'hFFF28313, 32'h300);
        bus.ex_ready_i = 1'b0;
        bus.ins_i = i_t(12'd5, 5'd5, 3'b000, 5'd9, OPI);
        bus.if_valid_i = 1'b1;
        bus.flush_i = 1'b1;
        #1;
        chk++; if (bus.if_ready_o !== 1'b1) begin fails++; $display("FAIL flush_ready got=%h exp=1", bus.if_ready_o); end
        tick();
        chk++; if (bus.ex_valid_o !== 1'b0 || bus.ex_wb_reg_wr_o !== 1'b0 || bus.ex_imm_sel_o !== 1'b0)
            begin fails++; $display("FAIL flush_kill valid=%h wr=%h imm_sel=%h exp=0,0,0", bus.ex_valid_o, bus.ex_wb_reg_wr_o, bus.ex_imm_sel_o); end
        bus.flush_i = 1'b0;
        bus.if_valid_i = 1'b0;
        bus.ex_ready_i = 1'b1;
        tick();
        chk++; if (bus.ex_valid_o !== 1'b0) begin fails++; $display("FAIL flush_dropped got=%h exp=0", bus.ex_valid_o); end
    endtask

    task automatic test_illegal();
        logic [31:0] tv [16];
        logic [1:0]  te [16];
        tv = '{32'h0000007F, r_t(7'h40, 5'd2, 5'd1, 3'b000, 5'd3, OPR), r_t(7'h20, 5'd2, 5'd1, 3'b000, 5'd3, OPR),
               r_t(7'h20, 5'd2, 5'd1, 3'b010, 5'd3, OPR), r_t(7'h20, 5'd5, 5'd1, 3'b001, 5'd3, OPI),
               r_t(7'h20, 5'd5, 5'd1, 3'b101, 5'd3, OPI), i_t(12'd0, 5'd1, 3'b011, 5'd3, LD),
               i_t(12'd0, 5'd1, 3'b101, 5'd3, LD), s_t(12'd0, 5'd2, 5'd1, 3'b011),
               b_t(13'h8, 5'd2, 5'd1, 3'b010), b_t(13'h8, 5'd2, 5'd1, 3'b111),
               i_t(12'd0, 5'd1, 3'b001, 5'd3, JALR), i_t(12'd0, 5'd1, 3'b000, 5'd3, JALR),
               32'h00000032, 32'h0000000F, i_t(12'h800, 5'd1, 3'b010, 5'd3, OPI)};
        te = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01,
               2'b10, 2'b10, 2'b00, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
        for (int k = 0; k < 16; k++) begin
            issue(tv[k], 32'h400 + 32'(k * 4));
            chk++; if (bus.ex_valid_o !== 1'b1 || bus.ex_illegal_o !== te[k][1] || bus.ex_wb_reg_wr_o !== te[k][0])
                begin fails++; $display("FAIL illegal%0d ins=%h valid=%h ill=%h wr=%h exp=1,%h,%h", k, tv[k], bus.ex_valid_o, bus.ex_illegal_o, bus.ex_wb_reg_wr_o, te[k][1], te[k][0]); end
        end
        issue(r_t(7'h20, 5'd5, 5'd1, 3'b101, 5'd3, OPI), 32'h500);
        chk++; if (bus.ex_f7_o !== 7'h20 || bus.ex_f3_o !== 3'b101)
            begin fails++; $display("FAIL srai_f7 f7=%h f3=%h exp=20,5", bus.ex_f7_o, bus.ex_f3_o); end
        issue(i_t(12'h400, 5'd1, 3'b000, 5'd3, OPI), 32'h504);
        chk++; if (bus.ex_f7_o !== 7'h00) begin fails++; $display("FAIL addi_f7 got=%h exp=00", bus.ex_f7_o); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_d1;
`ifdef ID_RF_BYPASS_EN
        exp_d1 = 32'hAA;
`else
        exp_d1 = 32'h55;
`endif
        wr(5'd9, 32'h55);
        bus.wb_we_i = 1'b1;
        bus.wb_waddr_i = 5'd9;
        bus.wb_wdata_i = 32'hAA;
        issue(r_t(7'h00, 5'd0, 5'd9, 3'b000, 5'd1, OPR), 32'h600);
        bus.wb_we_i = 1'b0;
        chk++; if (bus.ex_d1_o !== exp_d1) begin fails++; $display("FAIL bypass_same_cycle got=%h exp=%h", bus.ex_d1_o, exp_d1); end
        issue(r_t(7'h00, 5'd0, 5'd9, 3'b000, 5'd1, OPR), 32'h604);
        chk++; if (bus.ex_d1_o !== 32'hAA) begin fails++; $display("FAIL bypass_after got=%h exp=000000aa", bus.ex_d1_o); end
        bus.wb_we_i = 1'b1;
        bus.wb_waddr_i = 5'd0;
        bus.wb_wdata_i = 32'hDEAD;
        issue(r_t(7'h00, 5'd0, 5'd0, 3'b000, 5'd1, OPR), 32'h608);
        bus.wb_we_i = 1'b0;
        chk++; if (bus.ex_d1_o !== 32'h0 || bus.ex_d2_o !== 32'h0)
            begin fails++; $display("FAIL x0_same_cycle d1=%h d2=%h exp=0,0", bus.ex_d1_o, bus.ex_d2_o); end
        issue(r_t(7'h00, 5'd0, 5'd0, 3'b000, 5'd1, OPR), 32'h60C);
        chk++; if (bus.ex_d1_o !== 32'h0) begin fails++; $display("FAIL x0_after got=%h exp=0", bus.ex_d1_o); end
    endtask

    task automatic test_rv32e();
        bus16.wb_we_i = 1'b1;
        bus16.wb_waddr_i = 5'd4;
        bus16.wb_wdata_i = 32'h44;
        tick();
        bus16.wb_waddr_i = 5'd20;
        bus16.wb_wdata_i = 32'h99;
        tick();
        bus16.wb_we_i = 1'b0;
        bus16.ins_i = r_t(7'h00, 5'd0, 5'd4, 3'b000, 5'd1, OPR);
        bus16.if_valid_i = 1'b1;
        tick();
        chk++; if (bus16.ex_d1_o !== 32'h44 || bus16.ex_illegal_o !== 1'b0)
            begin fails++; $display("FAIL e_oob_write d1=%h ill=%h exp=44,0", bus16.ex_d1_o, bus16.ex_illegal_o); end
        bus16.ins_i = r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd17, OPR);
        tick();
        chk++; if (bus16.ex_valid_o !== 1'b1 || bus16.ex_illegal_o !== 1'b1 || bus16.ex_wb_reg_wr_o !== 1'b0)
            begin fails++; $display("FAIL e_rd17 valid=%h ill=%h wr=%h exp=1,1,0", bus16.ex_valid_o, bus16.ex_illegal_o, bus16.ex_wb_reg_wr_o); end
        bus16.ins_i = i_t(12'd17, 5'd0, 3'b000, 5'd1, OPI);
        tick();
        bus16.if_valid_i = 1'b0;
        chk++; if (bus16.ex_illegal_o !== 1'b0 || bus16.ex_imm_o !== 32'd17)
            begin fails++; $display("FAIL e_addi_imm17 ill=%h imm=%h exp=0,11", bus16.ex_illegal_o, bus16.ex_imm_o); end
    endtask

    initial begin
        bus.if_valid_i = 1'b0; bus.ins_i = '0; bus.pc_i = '0; bus.flush_i = 1'b0; bus.ex_ready_i = 1'b1;
        bus.wb_we_i = 1'b0; bus.wb_waddr_i = '0; bus.wb_wdata_i = '0;
        bus16.if_valid_i = 1'b0; bus16.ins_i = '0; bus16.pc_i = '0; bus16.flush_i = 1'b0; bus16.ex_ready_i = 1'b1;
        bus16.wb_we_i = 1'b0; bus16.wb_waddr_i = '0; bus16.wb_wdata_i = '0;
        test_reset();
        test_addi();
        test_imm();
        test_load_use();
        test_stall();
        test_flush();
        test_illegal();
        test_bypass();
        test_rv32e();
        $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
        $finish;
    end
endmodule
